// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator: turns step commands into A/B Gray-coded edges.
// Latency: first edge STEP_DIV cycles after the accept cycle, then one edge every STEP_DIV cycles.
// Backpressure: cmd_ready is high only while idle; commands offered during a run are left pending.
//
// Ports:
//   clk        system clock, all state on posedge
//   reset      synchronous active-high reset, overrides everything
//   cmd_valid  command offered
//   cmd_ready  command can be taken this cycle (IDLE only)
//   cmd_dir    1 = count up, 0 = count down
//   cmd_steps  number of quadrature edges to emit (0 = consume, emit nothing)
//   abort      finish the current command after this cycle
//   enc_a      quadrature channel A (registered)
//   enc_b      quadrature channel B (registered)
//   busy       a command is being played out
//   pos_count  signed net edges since reset, wraps modulo 2**POS_W

module quad_encoder_gen #(
  parameter int STEP_DIV = 1000,
  parameter int CNT_W    = 8,
  parameter int POS_W    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_dir,
  input  logic [CNT_W-1:0]        cmd_steps,
  input  logic                    abort,
  output logic                    enc_a,
  output logic                    enc_b,
  output logic                    busy,
  output logic signed [POS_W-1:0] pos_count
);

  // Divider only needs to reach STEP_DIV-1.
  localparam int                      DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0]        DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [DIV_W-1:0]        DIV_ONE  = DIV_W'(1);
  localparam logic [CNT_W-1:0]        CNT_ONE  = CNT_W'(1);
  localparam logic signed [POS_W-1:0] POS_ONE  = POS_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [DIV_W-1:0]  divider;
  logic [CNT_W-1:0]  remaining;
  logic              dir;

  logic              accept;     // handshake fires this cycle
  logic              start;      // accepted command with a non-zero step count
  logic              edge_due;   // a quadrature edge is emitted at this posedge
  logic              last_edge;  // the edge that completes the command

  always_comb begin
    accept    = (state == IDLE) && cmd_valid;
    start     = accept && (cmd_steps != '0);
    edge_due  = (state == RUN) && (divider == DIV_LAST);
    last_edge = edge_due && (remaining == CNT_ONE);
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // A zero-step command is consumed without leaving IDLE. Abort in IDLE is a
  // no-op, so a command offered alongside it is still taken.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort || last_edge) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (decoded straight from the state flop)
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state == RUN);
  end

  // ---------------------------------------------------------------------------
  // Command bookkeeping: direction, edges left, edge-spacing divider.
  // The divider restarts at 0 on accept so the first edge lands exactly
  // STEP_DIV cycles later.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      dir       <= 1'b0;
      remaining <= '0;
      divider   <= '0;
    end else if (start) begin
      dir       <= cmd_dir;
      remaining <= cmd_steps;
      divider   <= '0;
    end else if (state == RUN) begin
      if (edge_due) begin
        divider   <= '0;
        remaining <= remaining - CNT_ONE;
      end else begin
        divider   <= divider + DIV_ONE;
      end
      // Abort overrides the countdown; an edge due this same cycle still goes out.
      if (abort) begin
        remaining <= '0;
        divider   <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Quadrature phase and position.
  // Up sequence  {A,B}: 00->10->11->01  => A' = ~B, B' = A
  // Down sequence{A,B}: 00->01->11->10  => A' = B,  B' = ~A
  // Exactly one channel changes per edge. The phase is held between commands.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      enc_a     <= 1'b0;
      enc_b     <= 1'b0;
      pos_count <= '0;
    end else if (edge_due) begin
      if (dir) begin
        enc_a     <= ~enc_b;
        enc_b     <= enc_a;
        pos_count <= pos_count + POS_ONE;
      end else begin
        enc_a     <= enc_b;
        enc_b     <= ~enc_a;
        pos_count <= pos_count - POS_ONE;
      end
    end
  end

endmodule

// File: tb/tb_quad_encoder_gen.sv
module tb_quad_encoder_gen;

  localparam int STEP_DIV = 4;
  localparam int CNT_W    = 8;
  localparam int POS_W    = 8;

  logic                    clk;
  logic                    reset;
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_dir;
  logic [CNT_W-1:0]        cmd_steps;
  logic                    abort;
  logic                    enc_a;
  logic                    enc_b;
  logic                    busy;
  logic signed [POS_W-1:0] pos_count;

  quad_encoder_gen #(
    .STEP_DIV(STEP_DIV),
    .CNT_W   (CNT_W),
    .POS_W   (POS_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_dir  (cmd_dir),
    .cmd_steps(cmd_steps),
    .abort    (abort),
    .enc_a    (enc_a),
    .enc_b    (enc_b),
    .busy     (busy),
    .pos_count(pos_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: each accepted command schedules its edges at
  // accept_cycle + k*STEP_DIV. The phase is a function of the net edge count.
  int  cyc;
  int  m_pos;
  bit  m_run;
  int  m_left;
  int  m_next;
  bit  m_dir;
  bit  m_rst_last;
  int  gray [4];

  initial begin
    gray[0] = 0;  // 00
    gray[1] = 2;  // 10
    gray[2] = 3;  // 11
    gray[3] = 1;  // 01
    cyc = 0; m_pos = 0; m_run = 0; m_left = 0; m_next = 0; m_dir = 0; m_rst_last = 1;
  end

  always @(posedge clk) begin
    cyc++;
    m_rst_last = reset;
    if (reset) begin
      m_pos = 0;
      m_run = 0;
    end else if (m_run) begin
      if (cyc == m_next) begin
        m_pos  = m_pos + (m_dir ? 1 : -1);
        m_left = m_left - 1;
        m_next = m_next + STEP_DIV;
        if (m_left == 0) m_run = 0;
      end
      if (abort) m_run = 0;
    end else if (cmd_valid && cmd_steps != 0) begin
      m_run  = 1;
      m_left = int'(cmd_steps);
      m_next = cyc + STEP_DIV;
      m_dir  = cmd_dir;
    end
  end

  function automatic int wrap_pos(input int v);
    logic signed [POS_W-1:0] t;
    t = v[POS_W-1:0];
    return int'(t);
  endfunction

  // Compare process: every cycle once reset has been applied.
  bit       chk_en = 0;
  bit       have_prev = 0;
  logic [1:0] prev_enc;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_enc",   int'({enc_a, enc_b}), gray[m_pos & 3]);
      chk("m_pos",   int'(pos_count), wrap_pos(m_pos));
      chk("m_busy",  int'(busy), int'(m_run));
      chk("m_ready", int'(cmd_ready), int'(!m_run));
      if (have_prev && !m_rst_last)
        chk("one_toggle", int'($countones({enc_a, enc_b} ^ prev_enc) <= 1), 1);
      prev_enc  = {enc_a, enc_b};
      have_prev = 1;
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Offer a command for one cycle; returns at the negedge after the accept posedge.
  task automatic issue(input logic d, input int n);
    cmd_valid = 1'b1;
    cmd_dir   = d;
    cmd_steps = n[CNT_W-1:0];
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ready(input int lim);
    int n;
    n = 0;
    while (!cmd_ready && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", int'(cmd_ready), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wait_n(1);
    reset = 1'b0;
  endtask

  initial begin
    int t2_exp [4];
    int t3_exp [3];
    t2_exp[0] = 2; t2_exp[1] = 3; t2_exp[2] = 1; t2_exp[3] = 0;
    t3_exp[0] = 1; t3_exp[1] = 3; t3_exp[2] = 2;

    reset = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_steps = '0; abort = 1'b0;
    wait_n(2);
    reset  = 1'b0;
    chk_en = 1;

    // T1: reset state
    chk("t1_enc",   int'({enc_a, enc_b}), 0);
    chk("t1_pos",   int'(pos_count), 0);
    chk("t1_ready", int'(cmd_ready), 1);
    chk("t1_busy",  int'(busy), 0);

    // T2: up 4 steps, edges every STEP_DIV cycles
    issue(1'b1, 4);
    chk("t2_busy", int'(busy), 1);
    wait_n(3);
    chk("t2_hold", int'({enc_a, enc_b}), 0);
    wait_n(1);
    chk("t2_e1", int'({enc_a, enc_b}), t2_exp[0]);
    for (int k = 1; k < 4; k++) begin
      wait_n(4);
      chk("t2_edge", int'({enc_a, enc_b}), t2_exp[k]);
    end
    chk("t2_pos",   int'(pos_count), 4);
    chk("t2_ready", int'(cmd_ready), 1);

    // T3: down 3 steps from 00
    do_reset();
    issue(1'b0, 3);
    for (int k = 0; k < 3; k++) begin
      wait_n(4);
      chk("t3_edge", int'({enc_a, enc_b}), t3_exp[k]);
    end
    chk("t3_pos", int'(pos_count), -3);

    // T4: zero-step command is consumed without any edge
    issue(1'b1, 0);
    chk("t4_ready", int'(cmd_ready), 1);
    chk("t4_busy",  int'(busy), 0);
    wait_n(5);
    chk("t4_enc", int'({enc_a, enc_b}), 2);
    chk("t4_pos", int'(pos_count), -3);

    // T5: abort sampled at accept+9 leaves two edges
    do_reset();
    issue(1'b1, 10);
    wait_n(8);
    abort = 1'b1;
    wait_n(1);
    abort = 1'b0;
    chk("t5_busy", int'(busy), 0);
    chk("t5_enc",  int'({enc_a, enc_b}), 3);
    chk("t5_pos",  int'(pos_count), 2);
    wait_n(8);
    chk("t5_hold", int'({enc_a, enc_b}), 3);
    chk("t5_pos2", int'(pos_count), 2);

    // T6: positive wrap, then reset in the middle of a run
    do_reset();
    issue(1'b1, 127);
    wait_ready(127 * STEP_DIV + 10);
    chk("t6_max", int'(pos_count), 127);
    issue(1'b1, 1);
    wait_ready(2 * STEP_DIV + 4);
    chk("t6_wrap", int'(pos_count), -128);
    chk("t6_wenc", int'({enc_a, enc_b}), 0);
    issue(1'b1, 255);
    wait_n(12);
    chk("t6_mid", int'({enc_a, enc_b}), 1);
    reset = 1'b1;
    wait_n(1);
    reset = 1'b0;
    chk("t6_renc",  int'({enc_a, enc_b}), 0);
    chk("t6_rbusy", int'(busy), 0);
    chk("t6_rpos",  int'(pos_count), 0);

    // Randomized traffic checked by the model
    for (int i = 0; i < 4000; i++) begin
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_dir   = $urandom_range(0, 1) == 1;
      cmd_steps = CNT_W'($urandom_range(0, 5));
      abort     = ($urandom_range(0, 29) == 0);
      reset     = ($urandom_range(0, 399) == 0);
      @(negedge clk);
    end
    cmd_valid = 1'b0; abort = 1'b0; reset = 1'b0;
    wait_n(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
